// File: rtl/odin_pkg.sv
// odin_pkg: shared types and constants for the ODIN AERIN front-end.
//   aer_state_t : handshake FSM state encoding used by aerin_scheduler.
//   AER_W       : default AER address width.
//   idx_w()     : width of a source index for n requesters (minimum 1 bit).
package odin_pkg;

    localparam int AER_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO,
        ERR_DRAIN
    } aer_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aerin_scheduler_if.sv
// aerin_scheduler_if: AERIN 4-phase REQ/ACK bus towards ODIN.
//   AERIN_ADDR : event address (driven by the scheduler)
//   AERIN_REQ  : 4-phase request (driven by the scheduler)
//   AERIN_ACK  : 4-phase acknowledge (driven by ODIN, asynchronous)
// Modports: master = scheduler side, slave = ODIN side.
interface aerin_scheduler_if
    import odin_pkg::*;
#(
    parameter int ADDR_W = AER_W
);

    logic [ADDR_W-1:0] AERIN_ADDR;
    logic              AERIN_REQ;
    logic              AERIN_ACK;

    modport master (output AERIN_ADDR, output AERIN_REQ, input AERIN_ACK);
    modport slave  (input AERIN_ADDR, input AERIN_REQ, output AERIN_ACK);

endinterface

// File: rtl/aerin_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       : request vector, one bit per source
//   last      : index of the previously granted source
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted source (0 when no request)
// The winner is the first requesting index scanning last+1, last+2, ...
// modulo N.
module rr_arbiter
    import odin_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDX_W'((32'(last) + k) % N);
            if (!w_found && req[idx]) begin
                w_found        = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/aerin_scheduler.sv
// aerin_scheduler: shares ODIN's AERIN input between N_SRC event sources.
//   clk, rst     : clock, synchronous active-high reset
//   src_addr     : packed per-source addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_valid    : source i has an event
//   src_ready    : accept strobe (combinational), transfer on valid & ready
//   enable, hold : new grants only when enable && !hold
//   aer          : AERIN bus (AERIN_ADDR/AERIN_REQ registered, AERIN_ACK async in)
//   grant_id     : index of the last granted source
//   busy         : handshake FSM not idle
//   timeout_err  : sticky abort flag, cleared by err_clr (a new set wins)
//   evt_count    : completed handshakes, wrapping
module aerin_scheduler
    import odin_pkg::*;
#(
    parameter  int N_SRC       = 2,
    parameter  int ADDR_W      = AER_W,
    parameter  int ACK_TIMEOUT = 1023,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = idx_w(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC*ADDR_W-1:0] src_addr,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic                    enable,
    input  logic                    hold,
    aerin_scheduler_if.master       aer,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr,
    output logic [CNT_W-1:0]        evt_count
);

    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TMO = TCNT_W'(ACK_TIMEOUT);

    aer_state_t          r_state, w_state_nx;
    logic [ADDR_W-1:0]   r_addr, w_addr_nx;
    logic                r_req, w_req_nx;
    logic [IDX_W-1:0]    r_last, w_last_nx;
    logic [IDX_W-1:0]    r_grant_id, w_gid_nx;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nx;
    logic                r_err, w_err_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic                r_sync1, r_sync2;
    logic                w_ack_s;
    logic                w_accept;
    logic [N_SRC-1:0]    w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [ADDR_W-1:0]   w_addr_arr [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_addr
        assign w_addr_arr[g] = src_addr[g*ADDR_W +: ADDR_W];
    end

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= aer.AERIN_ACK;
            r_sync2 <= r_sync1;
        end
    end
    assign w_ack_s = r_sync2;

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req       (src_valid),
        .last      (r_last),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Grant only once a leftover ACK from before a reset has been released,
    // otherwise the next REQ_HI would complete against a stale acknowledge.
    assign w_accept  = (r_state == IDLE) && enable && !hold && !w_ack_s && (|src_valid);
    assign src_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_req_nx   = r_req;
        w_last_nx  = r_last;
        w_gid_nx   = r_grant_id;
        w_tcnt_nx  = r_tcnt;
        w_err_nx   = r_err & ~err_clr;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_addr_nx  = w_addr_arr[w_grant_idx];
                    w_last_nx  = w_grant_idx;
                    w_gid_nx   = w_grant_idx;
                    w_tcnt_nx  = '0;
                    w_state_nx = SETUP;
                end
            end
            SETUP: begin
                w_req_nx   = 1'b1;
                w_state_nx = REQ_HI;
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_req_nx   = 1'b0;
                    w_tcnt_nx  = '0;
                    w_state_nx = REQ_LO;
                end else if (r_tcnt == TMO) begin
                    w_req_nx   = 1'b0;
                    w_err_nx   = 1'b1;
                    w_state_nx = ERR_DRAIN;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_cnt_nx   = r_cnt + 1'b1;
                    w_state_nx = IDLE;
                end else if (r_tcnt == TMO) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = ERR_DRAIN;
                end else begin
                    w_tcnt_nx = r_tcnt + 1'b1;
                end
            end
            ERR_DRAIN: begin
                if (!w_ack_s) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_req_nx   = 1'b0;
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_req      <= 1'b0;
            r_last     <= IDX_W'(N_SRC - 1);
            r_grant_id <= '0;
            r_tcnt     <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_req      <= w_req_nx;
            r_last     <= w_last_nx;
            r_grant_id <= w_gid_nx;
            r_tcnt     <= w_tcnt_nx;
            r_err      <= w_err_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    assign aer.AERIN_ADDR = r_addr;
    assign aer.AERIN_REQ  = r_req;
    assign grant_id       = r_grant_id;
    assign busy           = (r_state != IDLE);
    assign timeout_err    = r_err;
    assign evt_count      = r_cnt;

endmodule

// File: tb/tb_aerin_scheduler.sv
// tb_aerin_scheduler: directed self-checking bench for aerin_scheduler
// (N_SRC=2, ADDR_W=10, ACK_TIMEOUT=15, CNT_W=16).
module tb_aerin_scheduler;
    import odin_pkg::*;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] src_addr = '0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic            enable = 1'b1;
    logic            hold = 1'b0;
    logic [0:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic            err_clr = 1'b0;
    logic [CW-1:0]   evt_count;

    logic            resp_en = 1'b0;
    logic            resp_ack = 1'b0;
    logic            man_ack = 1'b0;

    int              checks = 0;
    int              errors = 0;
    int unsigned     exp_cnt = 0;

    always #5 clk = ~clk;

    aerin_scheduler_if #(.ADDR_W(AW)) aer ();
    assign aer.AERIN_ACK = resp_en ? resp_ack : man_ack;

    aerin_scheduler #(
        .N_SRC       (N),
        .ADDR_W      (AW),
        .ACK_TIMEOUT (15),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .src_addr    (src_addr),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .enable      (enable),
        .hold        (hold),
        .aer         (aer.master),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .evt_count   (evt_count)
    );

    // ODIN-like responder: raises ACK 3 cycles after seeing REQ, drops it
    // as soon as REQ falls.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!resp_en || rst) begin
                resp_ack = 1'b0;
                cnt = 0;
            end else if (!resp_ack) begin
                if (aer.AERIN_REQ) begin
                    cnt++;
                    if (cnt == 3) begin
                        resp_ack = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!aer.AERIN_REQ) begin
                resp_ack = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (aer.AERIN_REQ !== 1'b0 || aer.AERIN_ADDR !== 10'h000) begin
            errors++;
            $display("FAIL reset_aerin: req=%b addr=%h, want req=0 addr=000", aer.AERIN_REQ, aer.AERIN_ADDR);
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || evt_count !== 16'd0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b err=%b cnt=%0d gid=%0d, want all 0", busy, timeout_err, evt_count, grant_id);
        end
        checks++;
        if (src_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", src_ready);
        end
        rst = 1'b0;
        resp_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int rises;
        int ready_cyc;
        int addr_bad;
        logic prev_req;
        src_addr[9:0] = 10'h155;
        src_valid = 2'b01;
        #1;
        checks++;
        if (src_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b want 01", src_ready);
        end
        ready_cyc = (src_ready[0] === 1'b1) ? 1 : 0;
        tick();
        src_valid = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b1 || aer.AERIN_REQ !== 1'b0 || aer.AERIN_ADDR !== 10'h155 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL single_setup: busy=%b req=%b addr=%h gid=%0d, want 1 0 155 0", busy, aer.AERIN_REQ, aer.AERIN_ADDR, grant_id);
        end
        tick();
        checks++;
        if (aer.AERIN_REQ !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: req=%b want 1", aer.AERIN_REQ);
        end
        rises = 1;
        prev_req = aer.AERIN_REQ;
        addr_bad = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            tick();
            if (aer.AERIN_REQ && !prev_req) rises++;
            if (aer.AERIN_REQ && aer.AERIN_ADDR !== 10'h155) addr_bad++;
            if (src_ready[0]) ready_cyc++;
            prev_req = aer.AERIN_REQ;
        end
        exp_cnt++;
        checks++;
        if (busy !== 1'b0 || rises != 1 || addr_bad != 0) begin
            errors++;
            $display("FAIL single_pulse: busy=%b rises=%0d addr_bad=%0d, want 0 1 0", busy, rises, addr_bad);
        end
        checks++;
        if (ready_cyc != 1) begin
            errors++;
            $display("FAIL single_ready_cycles: got %0d want 1", ready_cyc);
        end
        checks++;
        if (evt_count !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL single_count: got %0d want %0d", evt_count, exp_cnt);
        end
    endtask

    task automatic test_gating();
        int bad;
        hold = 1'b1;
        src_addr[19:10] = 10'h2AA;
        src_valid = 2'b10;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (src_ready !== 2'b00 || aer.AERIN_REQ !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gate_hold: %0d cycles with activity, want 0", bad);
        end
        hold = 1'b0;
        #1;
        checks++;
        if (src_ready !== 2'b10) begin
            errors++;
            $display("FAIL gate_release_ready: got %b want 10", src_ready);
        end
        tick();
        src_valid = 2'b00;
        #1;
        checks++;
        if (grant_id !== 1'b1 || aer.AERIN_ADDR !== 10'h2AA) begin
            errors++;
            $display("FAIL gate_grant: gid=%0d addr=%h, want 1 2AA", grant_id, aer.AERIN_ADDR);
        end
        for (int i = 0; i < 60 && busy; i++) tick();
        exp_cnt++;
        // hold raised mid-handshake: transfer still completes, no new grant
        src_addr[19:10] = 10'h0F0;
        src_valid = 2'b10;
        tick();
        src_valid = 2'b00;
        for (int i = 0; i < 10 && !aer.AERIN_REQ; i++) tick();
        hold = 1'b1;
        src_valid = 2'b11;
        for (int i = 0; i < 60 && busy; i++) tick();
        exp_cnt++;
        checks++;
        if (busy !== 1'b0 || evt_count !== CW'(exp_cnt) || aer.AERIN_ADDR !== 10'h0F0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL gate_hold_midflight: busy=%b cnt=%0d addr=%h err=%b, want 0 %0d 0F0 0", busy, evt_count, aer.AERIN_ADDR, timeout_err, exp_cnt);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (src_ready !== 2'b00 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gate_hold_after: %0d cycles with activity, want 0", bad);
        end
        src_valid = 2'b00;
        hold = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic [9:0] seq [6];
        logic [9:0] exp_seq [6];
        int rises;
        logic prev_req;
        exp_seq = '{10'd1, 10'd2, 10'd1, 10'd2, 10'd1, 10'd2};
        for (int k = 0; k < 6; k++) seq[k] = '1;
        src_addr = {10'd2, 10'd1};
        src_valid = 2'b11;
        rises = 0;
        prev_req = aer.AERIN_REQ;
        for (int i = 0; i < 200 && rises < 6; i++) begin
            tick();
            if (aer.AERIN_REQ && !prev_req) begin
                seq[rises] = aer.AERIN_ADDR;
                rises++;
                if (rises == 6) src_valid = 2'b00;
            end
            prev_req = aer.AERIN_REQ;
        end
        src_valid = 2'b00;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (seq[k] !== exp_seq[k]) begin
                errors++;
                $display("FAIL fair_seq[%0d]: got %0d want %0d", k, seq[k], exp_seq[k]);
            end
        end
        for (int i = 0; i < 60 && busy; i++) tick();
        exp_cnt += 6;
        checks++;
        if (evt_count !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL fair_count: got %0d want %0d", evt_count, exp_cnt);
        end
    endtask

    task automatic test_timeout();
        int hi;
        resp_en = 1'b0;
        man_ack = 1'b0;
        src_addr[9:0] = 10'h3C3;
        src_valid = 2'b01;
        tick();
        src_valid = 2'b00;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (aer.AERIN_REQ) hi++;
        end
        checks++;
        if (hi != 16) begin
            errors++;
            $display("FAIL tmo_req_cycles: got %0d want 16", hi);
        end
        checks++;
        if (timeout_err !== 1'b1 || evt_count !== CW'(exp_cnt) || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_status: err=%b cnt=%0d busy=%b, want 1 %0d 0", timeout_err, evt_count, busy, exp_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: err=%b want 0", timeout_err);
        end
        // err_clr on the very edge that sets the flag again
        src_valid = 2'b01;
        tick();
        src_valid = 2'b00;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (aer.AERIN_REQ) hi++;
            if (hi == 16) begin
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                break;
            end
        end
        #1;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_set_wins: err=%b want 1", timeout_err);
        end
        for (int i = 0; i < 10 && busy; i++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_stuck_ack();
        int bad;
        resp_en = 1'b0;
        man_ack = 1'b0;
        src_addr = {10'h222, 10'h111};
        src_valid = 2'b01;
        tick();
        src_valid = 2'b00;
        for (int i = 0; i < 10 && !aer.AERIN_REQ; i++) tick();
        man_ack = 1'b1;
        src_valid = 2'b10;
        for (int i = 0; i < 60 && !timeout_err; i++) tick();
        checks++;
        if (timeout_err !== 1'b1 || aer.AERIN_REQ !== 1'b0 || busy !== 1'b1 || evt_count !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL stuck_tmo: err=%b req=%b busy=%b cnt=%0d, want 1 0 1 %0d", timeout_err, aer.AERIN_REQ, busy, evt_count, exp_cnt);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b1 || src_ready !== 2'b00 || aer.AERIN_REQ !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stuck_drain: %0d cycles left ERR_DRAIN early, want 0", bad);
        end
        man_ack = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 10 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0 || src_ready !== 2'b10) begin
            errors++;
            $display("FAIL stuck_next_ready: busy=%b ready=%b, want 0 10", busy, src_ready);
        end
        tick();
        src_valid = 2'b00;
        #1;
        checks++;
        if (grant_id !== 1'b1 || aer.AERIN_ADDR !== 10'h222) begin
            errors++;
            $display("FAIL stuck_next_grant: gid=%0d addr=%h, want 1 222", grant_id, aer.AERIN_ADDR);
        end
        for (int i = 0; i < 60 && busy; i++) tick();
        exp_cnt++;
        checks++;
        if (evt_count !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL stuck_count: got %0d want %0d", evt_count, exp_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        resp_en = 1'b0;
        man_ack = 1'b0;
        src_addr = {10'h155, 10'h0AA};
        src_valid = 2'b01;
        tick();
        src_valid = 2'b00;
        for (int i = 0; i < 10 && !aer.AERIN_REQ; i++) tick();
        man_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        exp_cnt = 0;
        checks++;
        if (aer.AERIN_REQ !== 1'b0 || busy !== 1'b0 || evt_count !== 16'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: req=%b busy=%b cnt=%0d err=%b, want 0 0 0 0", aer.AERIN_REQ, busy, evt_count, timeout_err);
        end
        rst = 1'b0;
        repeat (3) tick();
        src_valid = 2'b10;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (src_ready !== 2'b00 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_no_grant: %0d cycles granted with ACK high, want 0", bad);
        end
        man_ack = 1'b0;
        for (int i = 0; i < 6 && src_ready === 2'b00; i++) tick();
        checks++;
        if (src_ready !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_grant_after: ready=%b want 10", src_ready);
        end
        resp_en = 1'b1;
        tick();
        src_valid = 2'b00;
        for (int i = 0; i < 60 && busy; i++) tick();
        exp_cnt++;
        checks++;
        if (evt_count !== CW'(exp_cnt) || aer.AERIN_ADDR !== 10'h155) begin
            errors++;
            $display("FAIL rstmid_complete: cnt=%0d addr=%h, want %0d 155", evt_count, aer.AERIN_ADDR, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gating();
        test_fairness();
        test_timeout();
        test_stuck_ack();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
